// File: rtl/mandel_pkg.sv
// Shared types for the mandelbrot render scheduler: controller and slot states,
// default result width and pointer-width helper.
package mandel_pkg;

    localparam int DEFAULT_CTR_WIDTH = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DONE,
        ABORT
    } state_t;

    typedef enum logic [1:0] {
        EMPTY,
        ISSUED,
        ACTIVE,
        FULL
    } slot_t;

    // Pointers keep at least one bit so a single-engine build still has a legal vector.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mandel_render_scheduler_if.sv
// Engine dispatch/result bus plus framebuffer write port of the render scheduler.
// master = scheduler side, slave = engines and framebuffer side.
interface mandel_render_scheduler_if
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = 2,
    parameter int CTR_WIDTH   = DEFAULT_CTR_WIDTH,
    parameter int XW          = 8,
    parameter int YW          = 7
);
    logic [NUM_ENGINES-1:0]           eng_run;
    logic [XW-1:0]                    disp_x;
    logic [YW-1:0]                    disp_y;
    logic [NUM_ENGINES-1:0]           eng_running;
    logic [NUM_ENGINES*CTR_WIDTH-1:0] eng_ctr;
    logic                             write_mode;
    logic                             reset_write_ptr;
    logic                             fb_ready;
    logic                             fb_valid;
    logic [CTR_WIDTH-1:0]             fb_data;

    modport master (
        output eng_run, disp_x, disp_y, write_mode, reset_write_ptr, fb_valid, fb_data,
        input  eng_running, eng_ctr, fb_ready
    );

    modport slave (
        input  eng_run, disp_x, disp_y, write_mode, reset_write_ptr, fb_valid, fb_data,
        output eng_running, eng_ctr, fb_ready
    );
endinterface

// File: rtl/mandel_result_slot.sv
// One engine's result slot: follows the engine from issue through its busy period,
// captures the result on the busy falling edge and holds it until written out.
module mandel_result_slot
    import mandel_pkg::*;
#(
    parameter int CTR_WIDTH = DEFAULT_CTR_WIDTH
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 clear,
    input  logic                 issue,
    input  logic                 running,
    input  logic [CTR_WIDTH-1:0] ctr,
    input  logic                 accept,
    output logic                 full,
    output logic                 empty,
    output logic [CTR_WIDTH-1:0] data
);
    slot_t                slot_reg, slot_next;
    logic                 running_prev_reg;
    logic [CTR_WIDTH-1:0] data_reg;
    logic                 running_fall;

    assign running_fall = running_prev_reg & ~running;

    always_comb begin
        slot_next = slot_reg;
        if (clear) begin
            slot_next = EMPTY;
        end else begin
            case (slot_reg)
                EMPTY:   if (issue)        slot_next = ISSUED;
                ISSUED:  if (running)      slot_next = ACTIVE;
                ACTIVE:  if (running_fall) slot_next = FULL;
                FULL:    if (accept)       slot_next = EMPTY;
                default:                   slot_next = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_reg         <= EMPTY;
            running_prev_reg <= 1'b0;
            data_reg         <= '0;
        end else begin
            slot_reg         <= slot_next;
            running_prev_reg <= running;
            if (!clear && slot_reg == ACTIVE && running_fall)
                data_reg <= ctr;
        end
    end

    assign full  = (slot_reg == FULL);
    assign empty = (slot_reg == EMPTY);
    assign data  = data_reg;
endmodule

// File: rtl/mandel_render_scheduler.sv
// Raster-order render controller: round-robin dispatch of pixels to engines and
// in-order write-back of their results to the framebuffer.
module mandel_render_scheduler
    import mandel_pkg::*;
#(
    parameter int NUM_ENGINES = 2,
    parameter int CTR_WIDTH   = DEFAULT_CTR_WIDTH,
    parameter int H_PIXELS    = 160,
    parameter int V_PIXELS    = 120,
    parameter int XW          = 8,
    parameter int YW          = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic abort,
    input  logic continuous,
    output logic busy,
    output logic frame_done,
    mandel_render_scheduler_if.master bus
);
    localparam int TOTAL = H_PIXELS * V_PIXELS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = ptr_width(NUM_ENGINES);

    state_t                 state_reg, state_next;
    logic                   start_meta_reg, start_sync_reg, start_prev_reg;
    logic [XW-1:0]          x_reg, disp_x_reg;
    logic [YW-1:0]          y_reg, disp_y_reg;
    logic [PTR_W-1:0]       d_reg, w_reg;
    logic [CNT_W-1:0]       issued_reg, written_reg;
    logic [NUM_ENGINES-1:0] eng_run_reg;
    logic [NUM_ENGINES-1:0] sel_d, sel_w, slot_full, slot_empty;
    logic [CTR_WIDTH-1:0]   slot_data [NUM_ENGINES];
    logic [CTR_WIDTH-1:0]   fb_data_mux;
    logic                   start_rise, run_ok, dispatch, accept, slot_clear;

    assign start_rise = start_sync_reg & ~start_prev_reg;
    assign run_ok     = (state_reg == RUN) && !abort;
    assign slot_clear = (state_reg == ABORT) || (state_reg == CLEAR);

    // Only the engine at the dispatch pointer is considered: pixel k must land on
    // engine k mod NUM_ENGINES so that write order equals raster order.
    assign dispatch = run_ok && (issued_reg != CNT_W'(TOTAL))
                      && |(sel_d & slot_empty & ~bus.eng_running);
    assign accept   = run_ok && |(sel_w & slot_full) && bus.fb_ready;

    generate
        for (genvar gi = 0; gi < NUM_ENGINES; gi++) begin : g_slot
            assign sel_d[gi] = (d_reg == PTR_W'(gi));
            assign sel_w[gi] = (w_reg == PTR_W'(gi));

            mandel_result_slot #(.CTR_WIDTH(CTR_WIDTH)) u_slot (
                .clk     (clk),
                .reset   (reset),
                .clear   (slot_clear),
                .issue   (dispatch && sel_d[gi]),
                .running (bus.eng_running[gi]),
                .ctr     (bus.eng_ctr[gi*CTR_WIDTH +: CTR_WIDTH]),
                .accept  (accept && sel_w[gi]),
                .full    (slot_full[gi]),
                .empty   (slot_empty[gi]),
                .data    (slot_data[gi])
            );
        end
    endgenerate

    always_comb begin
        fb_data_mux = '0;
        for (int i = 0; i < NUM_ENGINES; i++)
            if (sel_w[i]) fb_data_mux = slot_data[i];
    end

    always_comb begin
        state_next          = state_reg;
        busy                = 1'b1;
        frame_done          = 1'b0;
        bus.write_mode      = 1'b0;
        bus.reset_write_ptr = 1'b0;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start_rise) state_next = CLEAR;
            end
            CLEAR: begin
                bus.write_mode      = 1'b1;
                bus.reset_write_ptr = 1'b1;
                state_next          = abort ? ABORT : RUN;
            end
            RUN: begin
                bus.write_mode = 1'b1;
                if (abort)                               state_next = ABORT;
                else if (written_reg == CNT_W'(TOTAL))   state_next = DONE;
            end
            DONE: begin
                bus.write_mode = 1'b1;
                frame_done     = 1'b1;
                state_next     = continuous ? CLEAR : IDLE;
            end
            ABORT: begin
                if (bus.eng_running == '0) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            start_meta_reg <= 1'b0;
            start_sync_reg <= 1'b0;
            start_prev_reg <= 1'b0;
            x_reg          <= '0;
            y_reg          <= '0;
            disp_x_reg     <= '0;
            disp_y_reg     <= '0;
            d_reg          <= '0;
            w_reg          <= '0;
            issued_reg     <= '0;
            written_reg    <= '0;
            eng_run_reg    <= '0;
        end else begin
            state_reg      <= state_next;
            start_meta_reg <= start;
            start_sync_reg <= start_meta_reg;
            start_prev_reg <= start_sync_reg;
            eng_run_reg    <= dispatch ? sel_d : '0;
            if (state_reg == CLEAR) begin
                x_reg       <= '0;
                y_reg       <= '0;
                d_reg       <= '0;
                w_reg       <= '0;
                issued_reg  <= '0;
                written_reg <= '0;
            end else begin
                if (dispatch) begin
                    disp_x_reg <= x_reg;
                    disp_y_reg <= y_reg;
                    issued_reg <= issued_reg + 1'b1;
                    if (x_reg == XW'(H_PIXELS - 1)) begin
                        x_reg <= '0;
                        y_reg <= y_reg + 1'b1;
                    end else begin
                        x_reg <= x_reg + 1'b1;
                    end
                    d_reg <= (d_reg == PTR_W'(NUM_ENGINES - 1)) ? '0 : d_reg + 1'b1;
                end
                if (accept) begin
                    written_reg <= written_reg + 1'b1;
                    w_reg       <= (w_reg == PTR_W'(NUM_ENGINES - 1)) ? '0 : w_reg + 1'b1;
                end
            end
        end
    end

    assign bus.eng_run  = eng_run_reg;
    assign bus.disp_x   = disp_x_reg;
    assign bus.disp_y   = disp_y_reg;
    assign bus.fb_valid = accept;
    assign bus.fb_data  = fb_data_mux;
endmodule

// File: doc/mandel_render_scheduler.md
Name: mandel_render_scheduler

Overview:
Parametrised render controller sitting between NUM_ENGINES mandelbrot iteration engines and the framebuffer write port. Generates the raster pixel sequence and dispatches pixels round-robin to idle engines. Collects results that may complete out of order and writes them to the framebuffer strictly in raster order. Adds abort, continuous re-render and multi-engine operation over the previous single-engine sequencer.

Parameters:
NUM_ENGINES, 2, number of engines served (1..8)
CTR_WIDTH, 4, width of one engine result word
H_PIXELS, 160, pixels per line
V_PIXELS, 120, lines per frame
XW, 8, width of disp_x (must hold H_PIXELS-1)
YW, 7, width of disp_y (must hold V_PIXELS-1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  asynchronous level; 2-flop synchronised, rising edge starts a frame
abort  in  1  synchronous; abandons current frame
continuous  in  1  sampled at frame end; 1 = restart immediately
eng_run  out  NUM_ENGINES  one-cycle start pulse, one bit per engine
disp_x  out  XW  pixel column, valid in the eng_run pulse cycle
disp_y  out  YW  pixel row, valid in the eng_run pulse cycle
eng_running  in  NUM_ENGINES  engine busy level
eng_ctr  in  NUM_ENGINES*CTR_WIDTH  engine results, engine e at [e*CTR_WIDTH +: CTR_WIDTH]
write_mode  out  1  framebuffer in write mode
reset_write_ptr  out  1  one-cycle framebuffer pointer clear
fb_ready  in  1  framebuffer can accept a word this cycle
fb_valid  out  1  write strobe; transfer when fb_valid && fb_ready
fb_data  out  CTR_WIDTH  result word
busy  out  1  state != IDLE
frame_done  out  1  one-cycle pulse after final pixel write

Behaviour:
- Reset: all outputs 0, state IDLE, all slots EMPTY, dispatch/write pointers 0, x=y=0.
- States: IDLE -> CLEAR on synchronised start rising edge; CLEAR (1 cycle: write_mode=1, reset_write_ptr=1) -> RUN; RUN -> DONE when written count reaches H_PIXELS*V_PIXELS; DONE (1 cycle: frame_done=1) -> CLEAR if continuous=1 else IDLE (write_mode=0). abort in CLEAR/RUN -> ABORT; ABORT holds write_mode=0, no dispatch, no writes, and exits to IDLE when all eng_running=0. abort ignored in IDLE/DONE. A start edge during ABORT is dropped.
- Per-engine slot states: EMPTY -> ISSUED (on eng_run) -> ACTIVE (eng_running seen 1) -> FULL (first cycle eng_running=0 after 1; eng_ctr captured that cycle) -> EMPTY (on accepted write).
- Dispatch (RUN only): target engine d = dispatch pointer. Issue when pixels remain, slot d EMPTY, eng_running[d]=0. Registered: eng_run[d]=1, disp_x/disp_y=current raster coordinate for exactly that cycle. Then x increments; at H_PIXELS-1 x wraps to 0 and y increments. d advances modulo NUM_ENGINES. At most one dispatch per cycle, strictly in order: never skip a busy engine.
- Write: slot at write pointer w (modulo NUM_ENGINES) FULL and fb_ready=1 -> fb_valid=1, fb_data=captured word for one cycle; slot becomes EMPTY, w advances. Out-of-order completions wait in their slot. A slot freed by a write may be redispatched the following cycle, not the same cycle.
- Pixel k always goes to engine k mod NUM_ENGINES. Therefore write order equals raster order.
- Simultaneous: completion and write of the same slot in one cycle is impossible (FULL precedes the write). Dispatch and write in the same cycle on different slots are allowed.
- Abort: all slots forced EMPTY on entry. Completions during ABORT are discarded. Pointers, x and y reset at CLEAR.
- Reset mid-frame: immediate return to the reset state. Engines are reset by the same signal.

Decomposition:
- Shared package mandel_pkg: state enum (IDLE, CLEAR, RUN, DONE, ABORT), slot enum (EMPTY, ISSUED, ACTIVE, FULL), default CTR_WIDTH.
- One sub-module mandel_result_slot, instantiated NUM_ENGINES times. It contains the running edge tracking, the slot state and the result register, with issue/accept inputs and full/empty outputs.

Test Plan:
1. N=2, H=4, V=2, engine models with fixed 5-cycle latency; pulse start -> reset_write_ptr 1 cycle after CLEAR entry. 8 fb writes with data = pixel index mod 16, in order 0..7. frame_done single pulse. write_mode falls afterwards.
2. N=2, engine 0 latency 20 and engine 1 latency 3 -> pixel 1 result held FULL until pixel 0 written. fb_data sequence stays raster order. disp_x/disp_y on eng_run go (0,0),(1,0),(2,0),(3,0),(0,1)...
3. fb_ready held 0 for 50 cycles mid-frame -> no fb_valid. Dispatch stalls after both slots FULL. Resuming fb_ready yields no lost or duplicated words (8 total).
4. abort asserted with both engines running -> write_mode=0 next cycle, no fb_valid. busy stays 1 until both eng_running low, then IDLE. A subsequent start renders a full correct frame.
5. continuous=1 at DONE -> CLEAR directly follows DONE, with a new reset_write_ptr pulse. Second frame data is identical to the first.
6. N=1, H=3, V=1 -> strictly serial operation: eng_run is never issued before the previous result is written. Exactly 3 writes.
